// File: rtl/vx_dmem_rsp_merge.sv
// Gathers per-lane TileLink D beats into one merged dcache response per load tag.
// Optional perf counters (perf_rsp_count, perf_stall_cycles) are built when DMEM_RSP_MERGE_PERF_EN is defined.
module vx_dmem_rsp_merge #(
  parameter int NUM_LANES   = 4,
  parameter int TAG_W       = 10,
  parameter int NUM_ENTRIES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alloc_valid,
  input  logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_LANES-1:0]       alloc_mask,
  output logic                       alloc_ready,
  input  logic [NUM_LANES-1:0]       d_valid,
  input  logic [3*NUM_LANES-1:0]     d_opcode,
  input  logic [TAG_W*NUM_LANES-1:0] d_source,
  input  logic [32*NUM_LANES-1:0]    d_data,
  output logic [NUM_LANES-1:0]       d_ready,
  output logic                       rsp_valid,
  output logic [NUM_LANES-1:0]       rsp_tmask,
  output logic [32*NUM_LANES-1:0]    rsp_data,
  output logic [TAG_W-1:0]           rsp_tag,
  input  logic                       rsp_ready,
  output logic                       err_orphan
`ifdef DMEM_RSP_MERGE_PERF_EN
  ,
  output logic [31:0]                perf_rsp_count,
  output logic [31:0]                perf_stall_cycles
`endif
);
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0]    vld_q, vld_n;
  logic [TAG_W-1:0]          tag_q  [NUM_ENTRIES];
  logic [TAG_W-1:0]          tag_n  [NUM_ENTRIES];
  logic [NUM_LANES-1:0]      exp_q  [NUM_ENTRIES];
  logic [NUM_LANES-1:0]      exp_n  [NUM_ENTRIES];
  logic [NUM_LANES-1:0]      rcv_q  [NUM_ENTRIES];
  logic [NUM_LANES-1:0]      rcv_n  [NUM_ENTRIES];
  logic [32*NUM_LANES-1:0]   data_q [NUM_ENTRIES];
  logic [32*NUM_LANES-1:0]   data_n [NUM_ENTRIES];

  logic [IDX_W-1:0]          out_idx, free_idx, sel_idx;
  logic [NUM_ENTRIES-1:0]    cmpl;
  logic                      free_any, tag_dup, alloc_fire, rsp_fire;
  logic                      orphan, lane_hit, load;

  assign d_ready  = '1;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    tag_dup  = 1'b0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (!vld_q[e]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(e);
      end
      if (vld_q[e] && (tag_q[e] == alloc_tag)) tag_dup = 1'b1;
    end
  end

  assign alloc_ready = reset && free_any && !tag_dup;
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_mask != '0);

  // Beats look only at pre-edge entry state, so a same-cycle alloc never catches its own tag's beat.
  always_comb begin
    vld_n    = vld_q;
    tag_n    = tag_q;
    exp_n    = exp_q;
    rcv_n    = rcv_q;
    data_n   = data_q;
    orphan   = 1'b0;
    lane_hit = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (d_valid[l] && (d_opcode[3*l +: 3] == 3'd1)) begin
        lane_hit = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (vld_q[e] && (tag_q[e] == d_source[TAG_W*l +: TAG_W]) &&
              exp_q[e][l] && !rcv_q[e][l]) begin
            lane_hit              = 1'b1;
            rcv_n[e][l]           = 1'b1;
            data_n[e][32*l +: 32] = d_data[32*l +: 32];
          end
        end
        if (!lane_hit) orphan = 1'b1;
      end
    end
    if (rsp_fire) vld_n[out_idx] = 1'b0;
    if (alloc_fire) begin
      vld_n[free_idx]  = 1'b1;
      tag_n[free_idx]  = alloc_tag;
      exp_n[free_idx]  = alloc_mask;
      rcv_n[free_idx]  = '0;
      data_n[free_idx] = '0;
    end
  end

  // Completion is judged on next-state masks so the last beat reaches the output one edge later.
  always_comb begin
    cmpl    = '0;
    sel_idx = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      cmpl[e] = vld_n[e] && (rcv_n[e] == exp_n[e]);
    end
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (cmpl[e]) sel_idx = IDX_W'(e);
    end
  end

  assign load = (|cmpl) && (!rsp_valid || rsp_ready);

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q      <= '0;
      rsp_valid  <= 1'b0;
      err_orphan <= 1'b0;
      out_idx    <= '0;
      rsp_tmask  <= '0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
    end else begin
      vld_q <= vld_n;
      if (orphan) err_orphan <= 1'b1;
      if (load) begin
        rsp_valid <= 1'b1;
        out_idx   <= sel_idx;
        rsp_tmask <= exp_n[sel_idx];
        rsp_data  <= data_n[sel_idx];
        rsp_tag   <= tag_n[sel_idx];
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    tag_q  <= tag_n;
    exp_q  <= exp_n;
    rcv_q  <= rcv_n;
    data_q <= data_n;
  end

`ifdef DMEM_RSP_MERGE_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_rsp_count    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (rsp_fire) perf_rsp_count <= perf_rsp_count + 32'd1;
      if (rsp_valid && !rsp_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
